// File: rtl/byte_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// byte_serial_add_ctrl
// Drives an external 8-bit adder one byte per clock, LSB first, to form a
// wide add/subtract result with carry, borrow and signed-overflow flags.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module byte_serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IW-1:0] c_LAST_IDX = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;        // already inverted in subtract mode
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_result;
    logic          r_cout;
    logic          r_ovf;

    logic          w_last;
    logic          w_accept;
    logic [7:0]    w_byte_a;
    logic [7:0]    w_byte_b;
    logic          w_ovf;

    assign w_last   = (r_idx == c_LAST_IDX);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_byte_a = r_a[8*r_idx +: 8];
    assign w_byte_b = r_b[8*r_idx +: 8];

    // Overflow: operands share a sign and the top result byte's sign differs.
    assign w_ovf = (r_a[W-1] == r_b[W-1]) && (add_sum[7] != r_a[W-1]);

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Output logic
    //--------------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        case (r_state)
            S_RUN: begin
                busy    = 1'b1;
                add_a   = w_byte_a;
                add_b   = w_byte_b;
                add_cin = r_carry;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Operand capture and byte-serial datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= op_a;
            r_b      <= sub ? ~op_b : op_b;
            r_carry  <= sub | cin;
            r_idx    <= '0;
            r_result <= '0;
        end else if (r_state == S_RUN) begin
            r_result[8*r_idx +: 8] <= add_sum;
            r_carry                <= add_cout;
            r_idx                  <= r_idx + 1'b1;
            if (w_last) begin
                r_cout <= add_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule

`default_nettype wire
